// File: rtl/stopwatch_timer.sv
// Stopwatch / countdown timer with MM:SS.cc BCD count, debounced buttons and
// registered seven-segment outputs.

module stopwatch_debounce #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Accept a new level after CYCLES consecutive differing samples; pulse on press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      press  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press   <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

module stopwatch_timer #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       mode,
  input  logic [5:0] load_mins,
  input  logic [5:0] load_secs,
  output logic [7:0] ten_mins_seven_seg,
  output logic [7:0] one_min_seven_seg,
  output logic [7:0] ten_secs_seven_seg,
  output logic [7:0] one_sec_seven_seg,
  output logic [7:0] tenths_seven_seg,
  output logic [7:0] hundredths_seven_seg,
  output logic       overflow_flag,
  output logic       done_flag
);

  localparam int unsigned PRE_MAX   = CLK_HZ / 100 - 1;
  localparam int unsigned PRE_W     = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam int unsigned CNT_W     = 24;
  localparam logic [CNT_W-1:0] COUNT_MAX = 24'h595999;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE,
    S_OVERFLOW
  } state_t;

  state_t             state_q, state_nxt;
  logic               mode_q;
  logic [PRE_W-1:0]   pre_q;
  logic [CNT_W-1:0]   count_q, capture_q;
  logic               freeze_q;

  logic               ss_p, lap_p, clr_p;
  logic               tick_c, mode_eff_c;
  logic               do_clear_c, lap_tgl_c, go_done_c, go_ovf_c;
  logic [CNT_W-1:0]   count_inc_c, count_dec_c, preset_c, disp_c;
  logic [5:0]         min_cl_c, sec_cl_c;

  // Digit limits come from COUNT_MAX: nibble i wraps at COUNT_MAX[i]
  function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == COUNT_MAX[i*4 +: 4]) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = COUNT_MAX[i*4 +: 4];
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] d, input logic dp);
    logic [6:0] pat;
    logic [7:0] r;
    case (d)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    r = {dp, pat};
    return SEG_ACTIVE_LOW ? ~r : r;
  endfunction

  stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk(CLK_50), .rst(reset), .btn_n(start_stop), .press(ss_p)
  );
  stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(CLK_50), .rst(reset), .btn_n(lap), .press(lap_p)
  );
  stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(CLK_50), .rst(reset), .btn_n(clear), .press(clr_p)
  );

  assign tick_c      = (state_q == S_RUN) && (pre_q == PRE_W'(PRE_MAX));
  assign mode_eff_c  = (state_q == S_IDLE) ? mode : mode_q;
  assign count_inc_c = bcd_inc(count_q);
  assign count_dec_c = bcd_dec(count_q);
  assign min_cl_c    = (load_mins > 6'd59) ? 6'd59 : load_mins;
  assign sec_cl_c    = (load_secs > 6'd59) ? 6'd59 : load_secs;
  assign preset_c    = {to_bcd(min_cl_c), to_bcd(sec_cl_c), 8'h00};
  assign disp_c      = freeze_q ? capture_q : count_q;

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Button priority: clear > start_stop > lap; terminal ticks beat a pause
  always_comb begin
    state_nxt  = state_q;
    do_clear_c = 1'b0;
    lap_tgl_c  = 1'b0;
    go_done_c  = 1'b0;
    go_ovf_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_p) begin
          do_clear_c = 1'b1;
        end else if (ss_p) begin
          if (mode && (count_q == '0)) begin
            state_nxt = S_DONE;
            go_done_c = 1'b1;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (tick_c && !mode_q && (count_q == COUNT_MAX)) begin
          state_nxt = S_OVERFLOW;
          go_ovf_c  = 1'b1;
        end else if (tick_c && mode_q && ((count_q == '0) || (count_dec_c == '0))) begin
          state_nxt = S_DONE;
          go_done_c = 1'b1;
        end else if (ss_p) begin
          state_nxt = S_PAUSED;
        end else if (lap_p) begin
          lap_tgl_c = 1'b1;
        end
      end
      S_PAUSED: begin
        if (clr_p)      do_clear_c = 1'b1;
        else if (ss_p)  state_nxt  = S_RUN;
        else if (lap_p) lap_tgl_c  = 1'b1;
      end
      S_DONE, S_OVERFLOW: begin
        if (clr_p) do_clear_c = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (do_clear_c) state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      mode_q               <= 1'b0;
      pre_q                <= '0;
      count_q              <= '0;
      capture_q            <= '0;
      freeze_q             <= 1'b0;
      overflow_flag        <= 1'b0;
      done_flag            <= 1'b0;
      ten_mins_seven_seg   <= seg_encode(4'd0, 1'b0);
      one_min_seven_seg    <= seg_encode(4'd0, 1'b1);
      ten_secs_seven_seg   <= seg_encode(4'd0, 1'b0);
      one_sec_seven_seg    <= seg_encode(4'd0, 1'b1);
      tenths_seven_seg     <= seg_encode(4'd0, 1'b0);
      hundredths_seven_seg <= seg_encode(4'd0, 1'b0);
    end else begin
      if (state_q == S_IDLE) mode_q <= mode;

      if (do_clear_c)             pre_q <= '0;
      else if (state_q == S_RUN)  pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);

      if (do_clear_c) begin
        count_q <= mode_eff_c ? preset_c : '0;
      end else if (tick_c) begin
        if (!mode_q) begin
          if (count_q != COUNT_MAX) count_q <= count_inc_c;
        end else if (count_q != '0) begin
          count_q <= count_dec_c;
        end
      end

      if (do_clear_c) begin
        overflow_flag <= 1'b0;
        done_flag     <= 1'b0;
      end else begin
        if (go_ovf_c)  overflow_flag <= 1'b1;
        if (go_done_c) done_flag     <= 1'b1;
      end

      if (do_clear_c) begin
        freeze_q <= 1'b0;
      end else if (lap_tgl_c) begin
        freeze_q <= ~freeze_q;
        if (!freeze_q) capture_q <= count_q;
      end

      ten_mins_seven_seg   <= seg_encode(disp_c[23:20], 1'b0);
      one_min_seven_seg    <= seg_encode(disp_c[19:16], 1'b1);
      ten_secs_seven_seg   <= seg_encode(disp_c[15:12], 1'b0);
      one_sec_seven_seg    <= seg_encode(disp_c[11:8],  1'b1);
      tenths_seven_seg     <= seg_encode(disp_c[7:4],   1'b0);
      hundredths_seven_seg <= seg_encode(disp_c[3:0],   1'b0);
    end
  end

endmodule
